// File: rtl/gate_study_pkg.sv
// Shared types and constants for the gate study stimulus/checker blocks.
package gate_study_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default gate input vector width and hold counter width
  localparam int GATE_N_IN = 3;
  localparam int HOLD_W    = 8;

  // Reference truth tables for the three-input gates under study
  localparam logic [7:0] TT_AND3 = 8'h80;
  localparam logic [7:0] TT_OR3  = 8'hFE;
  localparam logic [7:0] TT_XOR3 = 8'h96;

endpackage

// File: rtl/gate_hold_timer.sv
// Hold-window timer: counts 0..HOLD-1 while running and flags the last
// cycle of each window so the controller knows when to sample and advance.
module gate_hold_timer
  import gate_study_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic last
);

  localparam logic [HOLD_W-1:0] LAST_CNT = HOLD_W'(HOLD - 1);
  localparam logic [HOLD_W-1:0] CNT_ONE  = HOLD_W'(1);

  logic [HOLD_W-1:0] cnt_reg;

  // Strobe is only meaningful while the sweep is running
  assign last = run && (cnt_reg == LAST_CNT);

  // Window counter: cleared on restart, wraps to zero after the last cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (restart) begin
      cnt_reg <= '0;
    end else if (run) begin
      cnt_reg <= last ? '0 : cnt_reg + CNT_ONE;
    end
  end

endmodule

// File: rtl/gate_stim_seq.sv
// Clocked stimulus/checker for a combinational gate: sweeps every input
// combination, samples the gate at the end of each hold window, builds the
// observed truth table and counts disagreements with the expected table.
module gate_stim_seq
  import gate_study_pkg::*;
#(
  parameter int                   N_IN        = GATE_N_IN,
  parameter int                   HOLD        = 4,
  parameter logic [2**N_IN-1:0]   EXPECTED_TT = TT_AND3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 y_in,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt_obs,
  output logic [N_IN:0]        mismatch_cnt,
  output logic                 pass
);

  localparam logic [N_IN-1:0] VEC_MAX = '1;
  localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);
  localparam logic [N_IN:0]   CNT_ONE = (N_IN + 1)'(1);

  state_t            state_reg;
  logic              sweep_go;
  logic              timer_run;
  logic              last;
  logic              y_miss;
  logic [N_IN:0]     mismatch_next;

  // A start request is honoured only outside a running sweep
  assign sweep_go      = start && (state_reg != RUN);
  assign timer_run     = (state_reg == RUN);
  assign y_miss        = (y_in != EXPECTED_TT[vec]);
  assign mismatch_next = mismatch_cnt + (y_miss ? CNT_ONE : '0);

  gate_hold_timer #(
    .HOLD (HOLD)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (sweep_go),
    .run     (timer_run),
    .last    (last)
  );

  // Sweep FSM with registered outputs, truth-table capture and compare
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      vec          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tt_obs       <= '0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg    <= RUN;
            vec          <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            tt_obs       <= '0;
            mismatch_cnt <= '0;
          end
        end
        RUN: begin
          if (last) begin
            tt_obs[vec]  <= y_in;
            mismatch_cnt <= mismatch_next;
            if (vec == VEC_MAX) begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (mismatch_next == '0);
            end else begin
              vec <= vec + VEC_ONE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gate_stim_seq.md
Name: gate_stim_seq

Overview:
- Upstream stimulus/checker stage for the combinational `gate` block.
- Walks the gate input vector {a,b,c} through every combination, holding each for a programmable number of cycles.
- At the end of each hold window it samples the gate output, builds the observed truth table and counts mismatches against an expected table.
- Provides a self-checking, clocked wrapper so the gate studies run without a hand-written stimulus list.

Parameters:
- N_IN, 3, number of gate inputs; vector width.
- HOLD, 4, cycles each vector is held; legal range 1..255.
- EXPECTED_TT, 8'h80, expected truth table; bit i = expected output for vector value i; width 2**N_IN.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to begin a sweep.
- y_in  in  1  output of the gate under test.
- vec  out  N_IN  drives gate inputs: vec[2]=a, vec[1]=b, vec[0]=c for N_IN=3.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; results valid.
- tt_obs  out  2**N_IN  observed truth table; bit i = sampled y_in for vector i.
- mismatch_cnt  out  N_IN+1  number of vectors where tt_obs differs from EXPECTED_TT.
- pass  out  1  done && (mismatch_cnt == 0).

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, vec=0, busy=0, done=0, tt_obs=0, mismatch_cnt=0, pass=0, hold counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN next cycle.
  - On that same edge, clear tt_obs, mismatch_cnt, vec and the hold counter.
- RUN:
  - busy=1; vec is stable for exactly HOLD cycles per value.
  - The hold counter counts 0..HOLD-1.
  - When the counter reaches HOLD-1, on that edge:
    - tt_obs[vec] <= y_in.
    - If y_in != EXPECTED_TT[vec], mismatch_cnt increments.
  - If vec is the maximum value (all ones), → DONE.
  - Otherwise vec increments and the counter resets to 0.
- Sampling: y_in is sampled in the last cycle of each window, giving the gate HOLD-1 cycles of settling.
- DONE:
  - busy=0, done=1; vec holds the last value; results hold.
  - start=1 → clears results, vec=0, → RUN (restart).
- start while in RUN is ignored.
- Latency:
  - start sampled at edge 0 → busy=1 from edge 0 through edge 2**N_IN*HOLD.
  - done=1 after edge 2**N_IN*HOLD.
  - For defaults, busy is high for 32 cycles.
- HOLD=1: vec changes every cycle, and y_in is sampled on every cycle.
- rst mid-sweep: on the next edge, return to IDLE with all reset values; partial results are discarded.
- rst and start together: rst wins.
- Counter widths:
  - mismatch_cnt is N_IN+1 bits, so it can hold 2**N_IN without wrap.
  - The hold counter is 8 bits.
- pass is registered together with done; it is never 1 while busy.

Decomposition:
- Shared package gate_study_pkg:
  - typedef for the state enum (IDLE/RUN/DONE).
  - localparam for the default vector width.
  - The default EXPECTED_TT constants for AND3/OR3/XOR3 (8'h80, 8'hFE, 8'h96).
- One natural sub-module: gate_hold_timer.
  - Loadable down/up counter.
  - Emits a last-cycle strobe after HOLD cycles.
  - Restarted by the FSM.
- The truth-table capture and compare logic stay in the top module.

Test Plan:
- Defaults, gate modelled as AND3, one-cycle start → vec steps 0..7, each held 4 cycles; done after 32 cycles; tt_obs=8'h80, mismatch_cnt=0, pass=1.
- EXPECTED_TT=8'h80 with gate modelled as OR3 → tt_obs=8'hFE, mismatch_cnt=6, pass=0.
- HOLD=1, XOR3 gate → vec changes every cycle; done after 8 cycles; tt_obs=8'h96, pass=1.
- rst asserted for 1 cycle while vec=3 → next cycle: busy=0, done=0, vec=0, tt_obs=0, mismatch_cnt=0; a new start gives a full, correct sweep.
- start pulsed again at vec=5 during RUN → ignored; sweep completes at 32 cycles from the original start.
- start in DONE → results cleared the next cycle, busy=1, vec=0; second sweep reproduces the first sweep's results.
- Gate output toggling only in the first cycle of each window (glitch model) → sampled values are still correct, because the sample is taken in the last hold cycle.
